// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle controller and the RV32I datapath.
// master: controller (reads IR fields/flags, drives controls); slave: datapath.
interface mc_control_fsm_if;
  logic       go;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       lt_zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       RegWrite;
  logic       MemWrite;
  logic       retire;
  logic       illegal_instr;

  modport master (
    input  go, op, funct3, funct7b5,
    input  Zero, lt_zero, mem_ready,
    output PCWrite, IRWrite, AdrSrc,
    output ALUSrcA, ALUSrcB, ResultSrc,
    output ImmSrc, ALUControl,
    output RegWrite, MemWrite,
    output retire, illegal_instr
  );

  modport slave (
    output go, op, funct3, funct7b5,
    output Zero, lt_zero, mem_ready,
    input  PCWrite, IRWrite, AdrSrc,
    input  ALUSrcA, ALUSrcB, ResultSrc,
    input  ImmSrc, ALUControl,
    input  RegWrite, MemWrite,
    input  retire, illegal_instr
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Moore control FSM for the RV32I multicycle datapath.
// Ports: clk, reset (async active-low), bus (controller side of the bundle).
module mc_control_fsm #(
  parameter bit RESET_TO_FETCH = 1'b1
) (
  input logic             clk,
  input logic             reset,
  mc_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB,
    MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH,
    JAL, JALR_ADR, JALR_JMP, TRAP, HALT
  } state_t;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] rsel;
    logic [3:0] aluc;
    logic       rw;
    logic       mw;
    logic       ret;
    logic       ill;
  } ctrl_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam ctrl_t FETCH_CTRL = '{
    pcw: 1'b0, adr: 1'b0, srca: 2'b00,
    srcb: 2'b10, rsel: 2'b10, aluc: 4'b0000,
    rw: 1'b0, mw: 1'b0, ret: 1'b0, ill: 1'b0
  };

  localparam state_t RST_ST =
    RESET_TO_FETCH ? FETCH : HALT;
  localparam ctrl_t RST_CTRL =
    RESET_TO_FETCH ? FETCH_CTRL : ctrl_t'('0);

  function automatic logic [3:0] alu_op(
    input logic [2:0] f3,
    input logic       f7,
    input logic       is_r
  );
    case (f3)
      3'b000:  alu_op = (is_r && f7) ? 4'b0001 : 4'b0000;
      3'b001:  alu_op = 4'b0110;
      3'b010:  alu_op = 4'b0101;
      3'b100:  alu_op = 4'b0100;
      3'b101:  alu_op = f7 ? 4'b1000 : 4'b0111;
      3'b110:  alu_op = 4'b0011;
      3'b111:  alu_op = 4'b0010;
      default: alu_op = 4'b0000;
    endcase
  endfunction

  function automatic ctrl_t dec(
    input state_t     s,
    input logic [2:0] f3,
    input logic       f7
  );
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:    c = FETCH_CTRL;
      DECODE:   begin c.srca = 2'b01; c.srcb = 2'b01; end
      MEMADR:   begin c.srca = 2'b10; c.srcb = 2'b01; end
      MEMREAD:  c.adr = 1'b1;
      MEMWB:    begin c.rsel = 2'b01; c.rw = 1'b1; c.ret = 1'b1; end
      MEMWRITE: begin c.adr = 1'b1; c.mw = 1'b1; end
      EXEC_R:   begin
        c.srca = 2'b10;
        c.aluc = alu_op(f3, f7, 1'b1);
      end
      EXEC_I:   begin
        c.srca = 2'b10;
        c.srcb = 2'b01;
        c.aluc = alu_op(f3, f7, 1'b0);
      end
      ALUWB:    begin c.rw = 1'b1; c.ret = 1'b1; end
      BRANCH:   begin
        c.srca = 2'b10;
        c.aluc = 4'b0001;
        c.ret  = 1'b1;
      end
      JAL, JALR_JMP: begin
        c.srca = 2'b01;
        c.srcb = 2'b10;
        c.pcw  = 1'b1;
      end
      JALR_ADR: begin c.srca = 2'b10; c.srcb = 2'b01; end
      TRAP:     c.ill = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  state_t     state_q, state_d;
  ctrl_t      ctrl_q;
  logic       alu_ok, br_ok, taken;
  logic [1:0] imm_sel;

  assign alu_ok = (bus.funct3 != 3'b011);
  assign br_ok  = (bus.funct3[2:1] != 2'b01) &&
                  (bus.funct3[2:1] != 2'b11);

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        unique case (1'b1)
          (bus.op == OP_LW),
          (bus.op == OP_SW):   state_d = MEMADR;
          (bus.op == OP_R):    state_d = alu_ok ? EXEC_R : TRAP;
          (bus.op == OP_I):    state_d = alu_ok ? EXEC_I : TRAP;
          (bus.op == OP_BR):   state_d = br_ok ? BRANCH : TRAP;
          (bus.op == OP_JAL):  state_d = JAL;
          (bus.op == OP_JALR): state_d = JALR_ADR;
          default:             state_d = TRAP;
        endcase
      end
      MEMADR: begin
        if (bus.funct3 != 3'b010) state_d = TRAP;
        else if (bus.op == OP_SW) state_d = MEMWRITE;
        else                      state_d = MEMREAD;
      end
      MEMREAD:  if (bus.mem_ready) state_d = MEMWB;
      MEMWRITE: if (bus.mem_ready) state_d = FETCH;
      MEMWB, ALUWB, BRANCH:        state_d = FETCH;
      EXEC_R, EXEC_I, JAL, JALR_JMP: state_d = ALUWB;
      JALR_ADR: state_d = JALR_JMP;
      TRAP:     state_d = TRAP;
      HALT:     if (bus.go) state_d = FETCH;
      default:  state_d = RST_ST;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RST_ST;
      ctrl_q  <= RST_CTRL;
    end else begin
      state_q <= state_d;
      ctrl_q  <= dec(state_d, bus.funct3, bus.funct7b5);
    end
  end

  // Branch outcome comes from the ALU in the same cycle, so it cannot
  // be registered ahead of time.
  always_comb begin
    case (bus.funct3)
      3'b000:  taken = bus.Zero;
      3'b001:  taken = !bus.Zero;
      3'b100:  taken = bus.lt_zero;
      3'b101:  taken = !bus.lt_zero;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    case (bus.op)
      OP_SW:   imm_sel = 2'b01;
      OP_BR:   imm_sel = 2'b10;
      OP_JAL:  imm_sel = 2'b11;
      default: imm_sel = 2'b00;
    endcase
  end

  logic fetch_go, mem_done, br_go;
  assign fetch_go = (state_q == FETCH) && bus.mem_ready;
  assign mem_done = (state_q == MEMWRITE) && bus.mem_ready;
  assign br_go    = (state_q == BRANCH) && taken;

  // Everything is gated with reset so nothing can strobe while it is low.
  assign bus.PCWrite    = reset && (ctrl_q.pcw || fetch_go || br_go);
  assign bus.IRWrite    = reset && fetch_go;
  assign bus.AdrSrc     = reset && ctrl_q.adr;
  assign bus.ALUSrcA    = {2{reset}} & ctrl_q.srca;
  assign bus.ALUSrcB    = {2{reset}} & ctrl_q.srcb;
  assign bus.ResultSrc  = {2{reset}} & ctrl_q.rsel;
  assign bus.ImmSrc     = {2{reset}} & imm_sel;
  assign bus.ALUControl = {4{reset}} & ctrl_q.aluc;
  assign bus.RegWrite   = reset && ctrl_q.rw;
  assign bus.MemWrite   = reset && ctrl_q.mw;
  assign bus.retire     = reset && (ctrl_q.ret || mem_done);
  assign bus.illegal_instr = reset && ctrl_q.ill;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-cycle vector table plus
// hand sequences for traps, mid-instruction reset and HALT start.
module tb_mc_control_fsm;

  localparam logic [6:0] R    = 7'b0110011;
  localparam logic [6:0] I    = 7'b0010011;
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] LUI  = 7'b0110111;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic        lt;
    logic        mr;
    logic [18:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  vec_t tv[$];

  mc_control_fsm_if bus();
  mc_control_fsm_if hbus();

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  mc_control_fsm #(.RESET_TO_FETCH(1'b0)) hdut (
    .clk(clk), .reset(reset), .bus(hbus)
  );

  always #5 clk = ~clk;

  // {PCWrite,IRWrite,AdrSrc}, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
  // ALUControl, {RegWrite,MemWrite,retire,illegal_instr}
  function automatic logic [18:0] ex(
    input logic [2:0] hi, input logic [1:0] sa,
    input logic [1:0] sb, input logic [1:0] rs,
    input logic [1:0] im, input logic [3:0] ac,
    input logic [3:0] lo
  );
    return {hi, sa, sb, rs, im, ac, lo};
  endfunction

  function automatic logic [18:0] got_main();
    return {bus.PCWrite, bus.IRWrite, bus.AdrSrc,
            bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
            bus.ImmSrc, bus.ALUControl, bus.RegWrite,
            bus.MemWrite, bus.retire, bus.illegal_instr};
  endfunction

  function automatic logic [18:0] got_halt();
    return {hbus.PCWrite, hbus.IRWrite, hbus.AdrSrc,
            hbus.ALUSrcA, hbus.ALUSrcB, hbus.ResultSrc,
            hbus.ImmSrc, hbus.ALUControl, hbus.RegWrite,
            hbus.MemWrite, hbus.retire, hbus.illegal_instr};
  endfunction

  task automatic chk(input string tag, input logic [18:0] got,
                     input logic [18:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic add(input logic [6:0] op, input logic [2:0] f3,
                     input logic f7, input logic z, input logic lt,
                     input logic mr, input logic [18:0] e);
    tv.push_back('{op, f3, f7, z, lt, mr, e});
  endtask

  task automatic step(input string tag, input logic [6:0] op,
                      input logic [2:0] f3, input logic f7,
                      input logic z, input logic lt, input logic mr,
                      input logic [18:0] e);
    @(negedge clk);
    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7;
    bus.Zero = z; bus.lt_zero = lt; bus.mem_ready = mr;
    #1;
    chk(tag, got_main(), e);
  endtask

  task automatic push_alu(input logic [6:0] op, input logic [2:0] f3,
                          input logic f7, input logic [1:0] sb,
                          input logic [3:0] ac);
    add(op, f3, f7, 0, 0, 1, ex(3'b110, 2'b00, 2'b10, 2'b10, 2'b00, 4'h0, 4'b0000));
    add(op, f3, f7, 0, 0, 1, ex(3'b000, 2'b01, 2'b01, 2'b00, 2'b00, 4'h0, 4'b0000));
    add(op, f3, f7, 0, 0, 1, ex(3'b000, 2'b10, sb,    2'b00, 2'b00, ac,   4'b0000));
    add(op, f3, f7, 0, 0, 1, ex(3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 4'b1010));
  endtask

  task automatic push_br(input logic [2:0] f3, input logic z,
                         input logic lt, input logic pw);
    add(BR, f3, 0, z, lt, 1, ex(3'b110, 2'b00, 2'b10, 2'b10, 2'b10, 4'h0, 4'b0000));
    add(BR, f3, 0, z, lt, 1, ex(3'b000, 2'b01, 2'b01, 2'b00, 2'b10, 4'h0, 4'b0000));
    add(BR, f3, 0, z, lt, 1, ex({pw, 2'b00}, 2'b10, 2'b00, 2'b00, 2'b10, 4'h1, 4'b0010));
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk({tag, "_rst"}, got_main(), 19'd0);
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  localparam logic [18:0] F00  = 19'b110_00_10_10_00_0000_0000;
  localparam logic [18:0] D00  = 19'b000_01_01_00_00_0000_0000;
  localparam logic [18:0] TRP  = 19'b000_00_00_00_00_0000_0001;

  initial begin
    bus.go = 0; bus.op = R; bus.funct3 = 0; bus.funct7b5 = 0;
    bus.Zero = 0; bus.lt_zero = 0; bus.mem_ready = 1;
    hbus.go = 0; hbus.op = R; hbus.funct3 = 0; hbus.funct7b5 = 0;
    hbus.Zero = 0; hbus.lt_zero = 0; hbus.mem_ready = 1;

    push_alu(R, 3'b000, 1, 2'b00, 4'b0001);
    push_alu(R, 3'b101, 1, 2'b00, 4'b1000);
    push_alu(R, 3'b110, 0, 2'b00, 4'b0011);
    push_alu(I, 3'b000, 1, 2'b01, 4'b0000);
    push_alu(I, 3'b010, 0, 2'b01, 4'b0101);
    push_alu(I, 3'b101, 0, 2'b01, 4'b0111);
    push_alu(I, 3'b001, 0, 2'b01, 4'b0110);

    add(LW, 3'b010, 0, 0, 0, 1, F00);
    add(LW, 3'b010, 0, 0, 0, 1, D00);
    add(LW, 3'b010, 0, 0, 0, 1, ex(3'b000, 2'b10, 2'b01, 2'b00, 2'b00, 4'h0, 4'b0000));
    add(LW, 3'b010, 0, 0, 0, 0, ex(3'b001, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 4'b0000));
    add(LW, 3'b010, 0, 0, 0, 0, ex(3'b001, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 4'b0000));
    add(LW, 3'b010, 0, 0, 0, 1, ex(3'b001, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 4'b0000));
    add(LW, 3'b010, 0, 0, 0, 1, ex(3'b000, 2'b00, 2'b00, 2'b01, 2'b00, 4'h0, 4'b1010));

    add(SW, 3'b010, 0, 0, 0, 0, ex(3'b000, 2'b00, 2'b10, 2'b10, 2'b01, 4'h0, 4'b0000));
    add(SW, 3'b010, 0, 0, 0, 1, ex(3'b110, 2'b00, 2'b10, 2'b10, 2'b01, 4'h0, 4'b0000));
    add(SW, 3'b010, 0, 0, 0, 1, ex(3'b000, 2'b01, 2'b01, 2'b00, 2'b01, 4'h0, 4'b0000));
    add(SW, 3'b010, 0, 0, 0, 1, ex(3'b000, 2'b10, 2'b01, 2'b00, 2'b01, 4'h0, 4'b0000));
    add(SW, 3'b010, 0, 0, 0, 0, ex(3'b001, 2'b00, 2'b00, 2'b00, 2'b01, 4'h0, 4'b0100));
    add(SW, 3'b010, 0, 0, 0, 1, ex(3'b001, 2'b00, 2'b00, 2'b00, 2'b01, 4'h0, 4'b0110));

    push_br(3'b000, 1, 0, 1);
    push_br(3'b000, 0, 0, 0);
    push_br(3'b001, 0, 0, 1);
    push_br(3'b001, 1, 0, 0);
    push_br(3'b100, 0, 1, 1);
    push_br(3'b101, 0, 0, 1);
    push_br(3'b101, 0, 1, 0);

    add(JAL, 3'b000, 0, 0, 0, 1, ex(3'b110, 2'b00, 2'b10, 2'b10, 2'b11, 4'h0, 4'b0000));
    add(JAL, 3'b000, 0, 0, 0, 1, ex(3'b000, 2'b01, 2'b01, 2'b00, 2'b11, 4'h0, 4'b0000));
    add(JAL, 3'b000, 0, 0, 0, 1, ex(3'b100, 2'b01, 2'b10, 2'b00, 2'b11, 4'h0, 4'b0000));
    add(JAL, 3'b000, 0, 0, 0, 1, ex(3'b000, 2'b00, 2'b00, 2'b00, 2'b11, 4'h0, 4'b1010));

    add(JALR, 3'b000, 0, 0, 0, 1, F00);
    add(JALR, 3'b000, 0, 0, 0, 1, D00);
    add(JALR, 3'b000, 0, 0, 0, 1, ex(3'b000, 2'b10, 2'b01, 2'b00, 2'b00, 4'h0, 4'b0000));
    add(JALR, 3'b000, 0, 0, 0, 1, ex(3'b100, 2'b01, 2'b10, 2'b00, 2'b00, 4'h0, 4'b0000));
    add(JALR, 3'b000, 0, 0, 0, 1, ex(3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 4'b1010));

    // reset held low for three cycles: nothing may be driven
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("reset_c%0d", i), got_main(), 19'd0);
    end
    @(posedge clk);
    #2 reset = 1'b1;

    for (int i = 0; i < tv.size(); i++)
      step($sformatf("row%0d", i), tv[i].op, tv[i].f3, tv[i].f7,
           tv[i].z, tv[i].lt, tv[i].mr, tv[i].exp);

    // unsupported opcode: sticky trap with no enables
    step("lui_fetch", LUI, 3'b000, 0, 0, 0, 1, F00);
    step("lui_decode", LUI, 3'b000, 0, 0, 0, 1, D00);
    for (int i = 0; i < 20; i++)
      step($sformatf("lui_trap%0d", i), LUI, 3'b000, 0, 0, 0, 1, TRP);
    pulse_reset("lui");
    step("lui_after", R, 3'b000, 0, 0, 0, 1, F00);

    // R-type with funct3 011 traps from DECODE
    step("r011_decode", R, 3'b011, 0, 0, 0, 1, D00);
    step("r011_trap", R, 3'b011, 0, 0, 0, 1, TRP);
    pulse_reset("r011");

    // unsupported branch funct3 traps from DECODE
    step("br010_fetch", BR, 3'b010, 0, 1, 0, 1,
         ex(3'b110, 2'b00, 2'b10, 2'b10, 2'b10, 4'h0, 4'b0000));
    step("br010_decode", BR, 3'b010, 0, 1, 0, 1,
         ex(3'b000, 2'b01, 2'b01, 2'b00, 2'b10, 4'h0, 4'b0000));
    step("br010_trap", BR, 3'b010, 0, 1, 0, 1,
         ex(3'b000, 2'b00, 2'b00, 2'b00, 2'b10, 4'h0, 4'b0001));
    pulse_reset("br010");

    // lb (funct3 000) traps out of MEMADR
    step("lb_fetch", LW, 3'b000, 0, 0, 0, 1, F00);
    step("lb_decode", LW, 3'b000, 0, 0, 0, 1, D00);
    step("lb_memadr", LW, 3'b000, 0, 0, 0, 1,
         ex(3'b000, 2'b10, 2'b01, 2'b00, 2'b00, 4'h0, 4'b0000));
    step("lb_trap", LW, 3'b000, 0, 0, 0, 1, TRP);
    pulse_reset("lb");

    // reset mid-store: MemWrite must drop immediately
    step("mid_fetch", SW, 3'b010, 0, 0, 0, 1,
         ex(3'b110, 2'b00, 2'b10, 2'b10, 2'b01, 4'h0, 4'b0000));
    step("mid_decode", SW, 3'b010, 0, 0, 0, 1,
         ex(3'b000, 2'b01, 2'b01, 2'b00, 2'b01, 4'h0, 4'b0000));
    step("mid_memadr", SW, 3'b010, 0, 0, 0, 0,
         ex(3'b000, 2'b10, 2'b01, 2'b00, 2'b01, 4'h0, 4'b0000));
    step("mid_memwr", SW, 3'b010, 0, 0, 0, 0,
         ex(3'b001, 2'b00, 2'b00, 2'b00, 2'b01, 4'h0, 4'b0100));
    #2 reset = 1'b0;
    #1 chk("mid_async", got_main(), 19'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    step("mid_after", R, 3'b000, 0, 0, 0, 1, F00);

    // HALT-start instance waits for go
    @(negedge clk);
    reset = 1'b0;
    #1 chk("halt_rst", got_halt(), 19'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk($sformatf("halt_idle%0d", i), got_halt(), 19'd0);
    end
    @(negedge clk);
    hbus.go = 1'b1;
    #1 chk("halt_go", got_halt(), 19'd0);
    @(negedge clk);
    hbus.go = 1'b0;
    #1 chk("halt_fetch", got_halt(), F00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle control unit that sequences the RV32I multicycle datapath.
- Decodes the latched instruction fields and drives all datapath mux selects, write enables and ALUControl from a Moore state machine.
- Gates memory-phase progress on a memory-ready handshake.
- Flags unsupported encodings by entering a sticky trap state.

Parameters:
- RESET_TO_FETCH, 1, after reset release, first state is FETCH (1) or HALT (0, wait for `go` pulse)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- go  in  1  leave HALT (used only when RESET_TO_FETCH=0)
- op  in  7  Instr[6:0]
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU result zero
- lt_zero  in  1  ALU result negative (signed compare)
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC register enable
- IRWrite  out  1  instruction/OldPC register enable
- AdrSrc  out  1  0=PC, 1=Result
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=A
- ALUSrcB  out  2  00=WriteData, 01=ImmExt, 10=4
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALU result
- ImmSrc  out  2  00=I, 01=S, 10=B, 11=J
- ALUControl  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sra
- RegWrite  out  1  register file write enable
- MemWrite  out  1  data memory write strobe
- retire  out  1  one-cycle pulse on the last cycle of each completed instruction
- illegal_instr  out  1  high while in TRAP

Behaviour:
- Reset (low, async): state <= FETCH (or HALT).
  - PCWrite, IRWrite, RegWrite, MemWrite, retire are forced 0 combinationally while reset is low.
  - Selects/ImmSrc/ALUControl reset to 0.
- Selects and enables are decoded from state. ImmSrc is decoded from op in every state. Unlisted signals are 0.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - IRWrite=PCWrite=mem_ready.
  - Stay in FETCH until mem_ready; then go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch/jal target into ALUOut). Next state by op:
  - 0000011 -> MEMADR
  - 0100011 -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR_ADR
  - else -> TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, add.
  - lw -> MEMREAD; sw -> MEMWRITE.
  - funct3 != 010 -> TRAP.
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold until mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, retire=1 -> FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until mem_ready. On mem_ready: retire=1 -> FETCH.
- EXEC_R: ALUSrcA=10, ALUSrcB=00 -> ALUWB.
- EXEC_I: ALUSrcA=10, ALUSrcB=01 -> ALUWB.
- ALU op mapping by funct3 (illegal funct3 -> TRAP from DECODE, no writes):
  - 000: add; sub only for R with funct7b5=1
  - 001: sll
  - 010: slt
  - 100: xor
  - 101: srl, or sra if funct7b5=1
  - 110: or
  - 111: and
  - 011: illegal
- ALUWB: ResultSrc=00, RegWrite=1, retire=1 -> FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite when taken:
  - 000 beq: Zero
  - 001 bne: !Zero
  - 100 blt: lt_zero
  - 101 bge: !lt_zero
  - other funct3 -> TRAP (decided in DECODE)
  - Then retire=1 -> FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 (PC <- target; ALUOut <- OldPC+4) -> ALUWB.
- JALR_ADR: ALUSrcA=10, ALUSrcB=01, add -> JALR_JMP.
- JALR_JMP: same controls as JAL -> ALUWB.
- TRAP: all enables 0, illegal_instr=1. Sticky until reset.
- HALT: all enables 0; go -> FETCH.
- Latency: lw 5 cycles, sw 4, R/I 4, branch 3, jal 4, jalr 5 (mem_ready=1 throughout). Each mem_ready=0 cycle adds one.
- Reset asserted mid-instruction: immediate return to reset state; no partial write occurs after assertion.

Test Plan:
- Reset low 3 cycles, mem_ready=1 -> all enables 0 during reset. First cycle after release: FETCH with IRWrite=PCWrite=1, ALUSrcB=10, ResultSrc=10.
- op=0110011, funct3=000, funct7b5=1 -> ALUControl=0001 in EXEC_R. RegWrite=1 and retire=1 in cycle 4. Back to FETCH in cycle 5.
- lw (0000011/010), mem_ready low 2 cycles in MEMREAD -> AdrSrc=1 held 3 cycles. MEMWB RegWrite=1, ResultSrc=01. Total 7 cycles.
- beq with Zero=1 -> PCWrite=1 in BRANCH. Repeat with Zero=0 -> PCWrite=0. bge with lt_zero=0 -> PCWrite=1.
- jalr (1100111) -> JALR_ADR, then JALR_JMP (PCWrite=1, ALUSrcA=01, ALUSrcB=10), then ALUWB (RegWrite=1).
- op=0110111 -> TRAP after DECODE, illegal_instr=1 stays high 20 cycles with no enables. Reset clears it.
